// File: rtl/pes_sar_pkg.sv
// Shared definitions for the pes_sar successive-approximation search block.
//   - FSM state codes (IDLE, WAIT, DECIDE, DONE)
//   - comparator flag vector {lt,eq,gt} and its legal one-hot values
//   - settle counter width
package pes_sar_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int unsigned FLAG_W = 3;
  localparam logic [FLAG_W-1:0] FLAG_LT = 3'b100;
  localparam logic [FLAG_W-1:0] FLAG_EQ = 3'b010;
  localparam logic [FLAG_W-1:0] FLAG_GT = 3'b001;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  // True when exactly one comparator flag is asserted.
  function automatic logic flags_onehot(input logic [FLAG_W-1:0] f);
    return (f == FLAG_LT) || (f == FLAG_EQ) || (f == FLAG_GT);
  endfunction

endpackage

// File: rtl/pes_sar_search.sv
// Successive-approximation search controller. Drives trial codes to an
// external magnitude comparator (operand B), reads back its lt/eq/gt flags
// and binary-searches the unknown operand A, MSB first.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 begin a search (honoured in IDLE only)
//   abort                 synchronous cancel during WAIT/DECIDE
//   cmp_lt/cmp_eq/cmp_gt  comparator flags (A<B, A==B, A>B)
//   trial_code            registered code driven to comparator B
//   busy                  search in progress (through the DONE cycle)
//   result                last found value, held until the next completion
//   result_valid          one-cycle pulse in DONE
//   err                   flags were not one-hot at a decision; held until start
module pes_sar_search
  import pes_sar_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] trial_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);
  localparam logic [WIDTH-1:0] CODE_MSB = WIDTH'(1) << (WIDTH - 1);
  // After driving a new trial, either wait for the comparator or decide at once.
  localparam logic [ST_W-1:0]  ST_TRIAL = (SETTLE > 0) ? ST_WAIT : ST_DECIDE;

  logic [ST_W-1:0]  state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, idx_m1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] trial_nxt, result_nxt, code_upd;
  logic             busy_nxt, result_valid_nxt, err_nxt;
  cmp_flags_t       flags;

  assign flags  = {cmp_lt, cmp_eq, cmp_gt};
  assign idx_m1 = idx - IDX_W'(1);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= IDX_MSB;
      cnt          <= '0;
      trial_code   <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      trial_code   <= trial_nxt;
      busy         <= busy_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      err          <= err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    cnt_nxt          = cnt;
    trial_nxt        = trial_code;
    busy_nxt         = busy;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    err_nxt          = err;
    code_upd         = trial_code;

    case (state)
      ST_IDLE: begin
        trial_nxt = '0;
        if (start) begin
          trial_nxt = CODE_MSB;
          idx_nxt   = IDX_MSB;
          cnt_nxt   = CNT_INIT;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = ST_TRIAL;
        end
      end

      ST_WAIT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          trial_nxt = '0;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = ST_DECIDE;
          end
        end
      end

      ST_DECIDE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          trial_nxt = '0;
          busy_nxt  = 1'b0;
        end else if (!flags_onehot(flags)) begin
          err_nxt          = 1'b1;
          result_nxt       = trial_code;
          result_valid_nxt = 1'b1;
          state_nxt        = ST_DONE;
        end else if (flags.eq) begin
          result_nxt       = trial_code;
          result_valid_nxt = 1'b1;
          state_nxt        = ST_DONE;
        end else begin
          // Trial bit is currently set: keep it when A is above, clear when below.
          code_upd[idx] = flags.gt;
          trial_nxt     = code_upd;
          if (idx == '0) begin
            result_nxt       = code_upd;
            result_valid_nxt = 1'b1;
            state_nxt        = ST_DONE;
          end else begin
            code_upd[idx_m1] = 1'b1;
            trial_nxt        = code_upd;
            idx_nxt          = idx_m1;
            cnt_nxt          = CNT_INIT;
            state_nxt        = ST_TRIAL;
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        trial_nxt = '0;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = ST_IDLE;
        trial_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pes_sar_search.sv
// Bench for pes_sar_search: two instances (WIDTH=2/SETTLE=0 and WIDTH=4/SETTLE=2)
// closed-loop with a behavioural comparator, checked every cycle against an
// expected trace derived from a plain binary search.
module tb_pes_sar_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start_v, abort_v, force_en;
  logic [3:0] a_v     [2];
  logic [2:0] force_f [2];
  logic [2:0] flags   [2];
  logic [1:0] trial0, result0;
  logic [3:0] trial1, result1;
  logic [1:0] busy_v, rv_v, err_v;
  logic [3:0] trial_v [2];
  logic [3:0] result_v[2];

  assign trial_v[0]  = {2'b00, trial0};
  assign trial_v[1]  = trial1;
  assign result_v[0] = {2'b00, result0};
  assign result_v[1] = result1;

  // Behavioural comparator with an override for fault/garbage injection.
  assign flags[0] = force_en[0] ? force_f[0] :
                    {a_v[0] < trial_v[0], a_v[0] == trial_v[0], a_v[0] > trial_v[0]};
  assign flags[1] = force_en[1] ? force_f[1] :
                    {a_v[1] < trial_v[1], a_v[1] == trial_v[1], a_v[1] > trial_v[1]};

  pes_sar_search #(.WIDTH(2), .SETTLE(0)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .cmp_lt(flags[0][2]), .cmp_eq(flags[0][1]), .cmp_gt(flags[0][0]),
    .trial_code(trial0), .busy(busy_v[0]), .result(result0),
    .result_valid(rv_v[0]), .err(err_v[0])
  );

  pes_sar_search #(.WIDTH(4), .SETTLE(2)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .cmp_lt(flags[1][2]), .cmp_eq(flags[1][1]), .cmp_gt(flags[1][0]),
    .trial_code(trial1), .busy(busy_v[1]), .result(result1),
    .result_valid(rv_v[1]), .err(err_v[1])
  );

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle, plus persistent model state.
  logic [3:0] e_trial [2];
  logic [3:0] e_result[2];
  logic       e_busy  [2];
  logic       e_rv    [2];
  logic       e_err   [2];
  logic       e_tchk  [2];
  logic [3:0] m_result[2];
  logic       m_err   [2];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle(input int g);
    e_trial[g]  = 4'h0;
    e_busy[g]   = 1'b0;
    e_rv[g]     = 1'b0;
    e_result[g] = m_result[g];
    e_err[g]    = m_err[g];
    e_tchk[g]   = 1'b1;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (e_tchk[g]) check($sformatf("u%0d trial_code", g), trial_v[g], e_trial[g]);
      check($sformatf("u%0d busy", g), {3'b0, busy_v[g]}, {3'b0, e_busy[g]});
      check($sformatf("u%0d result_valid", g), {3'b0, rv_v[g]}, {3'b0, e_rv[g]});
      check($sformatf("u%0d result", g), result_v[g], e_result[g]);
      check($sformatf("u%0d err", g), {3'b0, err_v[g]}, {3'b0, e_err[g]});
    end
  end

  // mode 0: normal search, 1: illegal flags at the first decision, 2: abort at N+1.
  // spam: keep start high through the busy period (including DONE).
  task automatic run(input int g, input logic [3:0] a, input int mode, input bit spam,
                     output int lat, output logic [3:0] got);
    int         w, s, n, done_c, ti, k;
    logic [3:0] trials[$];
    logic [3:0] code, t, exp_res;
    logic       exp_err;
    logic [2:0] bad;
    w    = (g == 0) ? 2 : 4;
    s    = (g == 0) ? 0 : 2;
    code = 4'h0;
    for (int b = w - 1; b >= 0; b--) begin
      t = code | (4'(1) << b);
      trials.push_back(t);
      if (t == a) break;
      if (a > t) code = t;
    end
    if (mode == 1) begin
      n = 1; exp_res = trials[0]; exp_err = 1'b1;
    end else begin
      n = trials.size(); exp_res = a; exp_err = 1'b0;
    end
    done_c = n * (s + 1) + 1;
    lat    = -1;
    got    = 4'h0;
    a_v[g] = a;

    @(posedge clk); #1;
    start_v[g] = 1'b1;
    abort_v[g] = 1'($urandom_range(0, 1));
    set_idle(g);
    m_err[g] = 1'b0;

    for (int c = 1; c <= done_c; c++) begin
      @(posedge clk); #1;
      if (rv_v[g] && lat < 0) begin lat = c; got = result_v[g]; end
      start_v[g]  = spam;
      abort_v[g]  = 1'b0;
      force_en[g] = 1'b0;
      if (mode == 2 && c == 2) begin
        start_v[g] = 1'b0;
        set_idle(g);
        break;
      end
      if (c < done_c) begin
        ti = (c - 1) / (s + 1);
        k  = (c - 1) % (s + 1);
        e_trial[g]  = trials[ti];
        e_busy[g]   = 1'b1;
        e_rv[g]     = 1'b0;
        e_err[g]    = 1'b0;
        e_result[g] = m_result[g];
        e_tchk[g]   = 1'b1;
        if (k < s) begin
          force_en[g] = 1'b1;
          force_f[g]  = (k == 0) ? 3'b111 : 3'($urandom);
        end else if (mode == 1) begin
          do bad = 3'($urandom); while (bad == 3'b100 || bad == 3'b010 || bad == 3'b001);
          force_en[g] = 1'b1;
          force_f[g]  = bad;
        end
        if (mode == 2 && c == 1) abort_v[g] = 1'b1;
      end else begin
        abort_v[g]  = 1'($urandom_range(0, 1));
        e_tchk[g]   = 1'b0;
        e_busy[g]   = 1'b1;
        e_rv[g]     = 1'b1;
        e_result[g] = exp_res;
        e_err[g]    = exp_err;
        m_result[g] = exp_res;
        m_err[g]    = exp_err;
      end
    end

    @(posedge clk); #1;
    if (rv_v[g] && lat < 0) begin lat = 99; got = result_v[g]; end
    start_v[g]  = 1'b0;
    abort_v[g]  = 1'b0;
    force_en[g] = 1'b0;
    set_idle(g);
  endtask

  // Reset asserted in the middle of a WIDTH=4 search must clear outputs at once.
  task automatic reset_mid();
    a_v[1] = 4'($urandom);
    @(posedge clk); #1;
    start_v[1] = 1'b1;
    set_idle(1);
    m_err[1] = 1'b0;
    @(posedge clk); #1;
    start_v[1]  = 1'b0;
    e_trial[1]  = 4'b1000;
    e_busy[1]   = 1'b1;
    e_err[1]    = 1'b0;
    e_result[1] = m_result[1];
    #2;
    m_result[0] = 4'h0; m_err[0] = 1'b0; set_idle(0);
    m_result[1] = 4'h0; m_err[1] = 1'b0; set_idle(1);
    rst_n = 1'b0;
    #1;
    check("async rst trial_code", trial_v[1], 4'h0);
    check("async rst busy", {3'b0, busy_v[1]}, 4'h0);
    check("async rst result", result_v[1], 4'h0);
    check("async rst result w2", result_v[0], 4'h0);
    check("async rst err", {3'b0, err_v[1]}, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int         lat;
  logic [3:0] got;
  int         g, mode;

  initial begin
    rst_n    = 1'b0;
    start_v  = '0;
    abort_v  = '0;
    force_en = '0;
    for (int i = 0; i < 2; i++) begin
      a_v[i] = 4'h0; force_f[i] = 3'b000;
      m_result[i] = 4'h0; m_err[i] = 1'b0;
      set_idle(i);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed anchors from the search rules.
    run(0, 4'b0010, 0, 1'b0, lat, got);
    check("w2 A=10 latency", 4'(lat), 4'd2);
    check("w2 A=10 result", got, 4'b0010);
    run(0, 4'b0001, 0, 1'b0, lat, got);
    check("w2 A=01 latency", 4'(lat), 4'd3);
    check("w2 A=01 result", got, 4'b0001);
    run(0, 4'b0000, 0, 1'b0, lat, got);
    check("w2 A=00 latency", 4'(lat), 4'd3);
    check("w2 A=00 result", got, 4'b0000);
    run(0, 4'b0011, 0, 1'b0, lat, got);
    check("w2 A=11 result", got, 4'b0011);
    run(1, 4'b0110, 0, 1'b0, lat, got);
    check("w4 A=0110 latency", 4'(lat), 4'd10);
    check("w4 A=0110 result", got, 4'b0110);
    run(1, 4'b1111, 0, 1'b0, lat, got);
    check("w4 A=1111 worst-case latency", 4'(lat), 4'd13);

    // Full sweeps, with start held high on odd values.
    for (int a = 0; a < 4; a++) run(0, 4'(a), 0, 1'(a), lat, got);
    for (int a = 0; a < 16; a++) begin
      run(1, 4'(a), 0, 1'(a), lat, got);
      check("w4 sweep result", got, 4'(a));
    end

    // Illegal flags, then recovery clears err.
    run(0, 4'b0001, 1, 1'b0, lat, got);
    run(0, 4'b0010, 0, 1'b0, lat, got);
    run(1, 4'b1001, 1, 1'b0, lat, got);
    run(1, 4'b0011, 0, 1'b0, lat, got);

    // Abort keeps the previous result.
    run(0, 4'b0000, 2, 1'b0, lat, got);
    check("w2 abort no valid", 4'(lat + 1), 4'd0);
    run(1, 4'b1100, 2, 1'b0, lat, got);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      g    = int'($urandom_range(0, 1));
      mode = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
      run(g, (g == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
          mode, 1'($urandom_range(0, 1)), lat, got);
    end

    reset_mid();
    run(1, 4'b0101, 0, 1'b0, lat, got);
    check("w4 after reset result", got, 4'b0101);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
